// File: rtl/tm1638_frame_sequencer.sv
// TM1638 refresh frame sequencer.
// Captures a snapshot of the display content and streams the full refresh
// transaction (data command, address command, 16 payload bytes, control
// command) as 18-bit words into the downstream SPI FIFO. The outgoing word
// sits in a single output register that only reloads when it is empty or
// being accepted. This keeps the word stable under backpressure and still
// allows one word per clock when the FIFO is not full.
module tm1638_frame_sequencer #(
  parameter int REFRESH_CYCLES = 0,
  parameter int WIDTH          = 18
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Update,
  input  logic [63:0]      i_Digits,
  input  logic [7:0]       i_Leds,
  input  logic [2:0]       i_Brightness,
  input  logic             i_Display_On,
  input  logic             i_FIFO_Full,
  output logic             o_Data_Valid,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Busy,
  output logic             o_Frame_Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA_CMD,
    S_ADDR_CMD,
    S_PAYLOAD,
    S_CTRL_CMD,
    S_DRAIN
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       idx_reg, idx_next;
  logic             pending_reg, pending_next;
  logic             valid_reg, valid_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             done_reg, done_next;

  logic [63:0]      digits_reg;
  logic [7:0]       leds_reg;
  logic [2:0]       bright_reg;
  logic             on_reg;
  logic             snap_en;

  logic             timer_expire;
  logic             accept;
  logic             can_load;
  logic [WIDTH-1:0] cur_word;
  logic [7:0]       digit_arr [8];

  // Build a FIFO word: write flag 0, STB-release flag, zero pad, data byte.
  function automatic logic [WIDTH-1:0] make_word(input logic end_flag, input logic [7:0] b);
    make_word = {1'b0, end_flag, 8'h00, b};
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    assign digit_arr[gi] = digits_reg[8*gi +: 8];
  end

  assign accept   = valid_reg && !i_FIFO_Full;
  assign can_load = !valid_reg || !i_FIFO_Full;

  // Optional periodic refresh timer. It runs only while idle with nothing
  // pending, and it restarts on any trigger.
  if (REFRESH_CYCLES > 0) begin : g_timer
    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_CYCLES - 1);
    logic [CW-1:0] cnt_reg;

    assign timer_expire = (state_reg == S_IDLE) && !pending_reg && (cnt_reg == CNT_LAST);

    // Refresh counter: clear on trigger, count in idle, hold while busy.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
        cnt_reg <= '0;
      end else if (i_Update || timer_expire) begin
        cnt_reg <= '0;
      end else if (state_reg == S_IDLE && !pending_reg) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end else begin : g_no_timer
    assign timer_expire = 1'b0;
  end

  // Word that the current state wants to emit, taken from the snapshot.
  always_comb begin
    cur_word = '0;
    case (state_reg)
      S_DATA_CMD: cur_word = make_word(1'b1, 8'h40);
      S_ADDR_CMD: cur_word = make_word(1'b0, 8'hC0);
      S_PAYLOAD: begin
        if (idx_reg[0])
          cur_word = make_word(idx_reg == 4'd15, {7'b0, leds_reg[idx_reg[3:1]]});
        else
          cur_word = make_word(1'b0, digit_arr[idx_reg[3:1]]);
      end
      S_CTRL_CMD: cur_word = make_word(1'b1, {4'b1000, on_reg, bright_reg});
      default:    cur_word = '0;
    endcase
  end

  // Next-state, output register and pending-request logic.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pending_next = pending_reg;
    valid_next   = valid_reg;
    data_next    = data_reg;
    done_next    = 1'b0;
    snap_en      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_Update || timer_expire) begin
          snap_en    = 1'b1;
          state_next = S_DATA_CMD;
        end
      end
      S_DATA_CMD, S_ADDR_CMD, S_PAYLOAD, S_CTRL_CMD: begin
        if (i_Update)
          pending_next = 1'b1;
        if (can_load) begin
          valid_next = 1'b1;
          data_next  = cur_word;
          case (state_reg)
            S_DATA_CMD: state_next = S_ADDR_CMD;
            S_ADDR_CMD: begin
              state_next = S_PAYLOAD;
              idx_next   = 4'd0;
            end
            S_PAYLOAD: begin
              if (idx_reg == 4'd15)
                state_next = S_CTRL_CMD;
              else
                idx_next = idx_reg + 4'd1;
            end
            default: state_next = S_DRAIN;
          endcase
        end
      end
      S_DRAIN: begin
        if (i_Update)
          pending_next = 1'b1;
        if (accept) begin
          valid_next = 1'b0;
          data_next  = '0;
          done_next  = 1'b1;
          if (pending_reg || i_Update) begin
            pending_next = 1'b0;
            snap_en      = 1'b1;
            state_next   = S_DATA_CMD;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control and output state registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      pending_reg <= 1'b0;
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pending_reg <= pending_next;
      valid_reg   <= valid_next;
      data_reg    <= data_next;
      done_reg    <= done_next;
    end
  end

  // Display content snapshot, taken when a frame starts.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      digits_reg <= '0;
      leds_reg   <= '0;
      bright_reg <= '0;
      on_reg     <= 1'b0;
    end else if (snap_en) begin
      digits_reg <= i_Digits;
      leds_reg   <= i_Leds;
      bright_reg <= i_Brightness;
      on_reg     <= i_Display_On;
    end
  end

  assign o_Data_Valid = valid_reg;
  assign o_Data       = data_reg;
  assign o_Busy       = (state_reg != S_IDLE);
  assign o_Frame_Done = done_reg;

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
// Testbench for tm1638_frame_sequencer: scoreboard of expected FIFO words
// built from the display values, directed and randomized frames, backpressure,
// retrigger merging, mid-frame reset and the periodic refresh timer.
module tb_tm1638_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        upd = 1'b0;
  logic        upd_t = 1'b0;
  logic [63:0] digits = '0;
  logic [7:0]  leds = '0;
  logic [2:0]  bright = '0;
  logic        on = 1'b0;
  logic        full = 1'b0;
  logic        full_t = 1'b0;

  logic        valid, busy, done;
  logic [17:0] data;
  logic        valid_t, busy_t, done_t;
  logic [17:0] data_t;

  int checks = 0;
  int failures = 0;
  int full_mode = 0;

  logic [17:0] exp_q[$];
  int          accepted = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  logic [17:0] last_word = '0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_data = '0;

  int          ncyc = 0;
  int          words_t = 0;
  int          done_t_cnt = 0;
  int          last_done_t = 0;
  bit          have_done_t = 1'b0;
  logic        prev_busy_t = 1'b0;

  tm1638_frame_sequencer dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Update(upd), .i_Digits(digits),
    .i_Leds(leds), .i_Brightness(bright), .i_Display_On(on),
    .i_FIFO_Full(full), .o_Data_Valid(valid), .o_Data(data),
    .o_Busy(busy), .o_Frame_Done(done)
  );

  tm1638_frame_sequencer #(.REFRESH_CYCLES(50)) dut_t (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Update(upd_t), .i_Digits(digits),
    .i_Leds(leds), .i_Brightness(bright), .i_Display_On(on),
    .i_FIFO_Full(full_t), .o_Data_Valid(valid_t), .o_Data(data_t),
    .o_Busy(busy_t), .o_Frame_Done(done_t)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the 19 words of one refresh frame for given display values.
  task automatic push_frame(input logic [63:0] d, input logic [7:0] l,
                            input logic [2:0] b, input logic o);
    logic [7:0] byte_v;
    exp_q.push_back(18'h10040);
    exp_q.push_back(18'h000C0);
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) byte_v = d[8*(k/2) +: 8];
      else            byte_v = {7'b0, l[k/2]};
      exp_q.push_back({1'b0, (k == 15), 8'h00, byte_v});
    end
    exp_q.push_back({2'b01, 8'h00, 8'h80 | {4'b0, o, b}});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (full_mode)
      1:       full = ~full;
      2:       full = 1'($urandom_range(0, 1));
      3:       full = 1'b1;
      default: full = 1'b0;
    endcase
  endtask

  task automatic pulse_update();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  task automatic clear_counts();
    accepted = 0;
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check_value("frames_done", done_cnt, target);
  endtask

  task automatic randomize_inputs();
    digits = {$urandom, $urandom};
    leds   = 8'($urandom);
    bright = 3'($urandom);
    on     = 1'($urandom);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    ncyc++;
    if (!rst_n) begin
      prev_stall  = 1'b0;
      have_done_t = 1'b0;
      words_t     = 0;
      prev_busy_t = 1'b0;
    end else begin
      if (valid) begin
        if (prev_stall) check_value("hold_data", data, prev_data);
        if (!full) begin
          if (exp_q.size() > 0) exp_w = exp_q.pop_front();
          else                  exp_w = 32'hBAD0BAD;
          check_value("word", data, exp_w);
          accepted++;
          last_word = data;
          $display("word %0d data=0x%05h", accepted, data);
        end
      end
      prev_stall = valid && full;
      prev_data  = data;
      if (done) done_cnt++;
      if (busy) busy_cnt++;

      if (valid_t && !full_t) words_t++;
      if (busy_t && !prev_busy_t && have_done_t)
        check_value("refresh_gap", ncyc - last_done_t, 50);
      prev_busy_t = busy_t;
      if (done_t) begin
        check_value("t_frame_words", words_t, 19);
        words_t     = 0;
        have_done_t = 1'b1;
        last_done_t = ncyc;
        done_t_cnt++;
        $display("timer frame %0d done at cycle %0d", done_t_cnt, ncyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check_value("rst_valid", valid, 0);
    check_value("rst_data", data, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Directed frame, FIFO never full
    digits = 64'h0706050403020100; leds = 8'hA5; bright = 3'd3; on = 1'b1;
    full_mode = 0;
    tick();
    clear_counts();
    push_frame(digits, leds, bright, on);
    pulse_update();
    check_value("busy_after_trigger", busy, 1);
    check_value("valid_latency", valid, 0);
    tick();
    check_value("first_valid", valid, 1);
    check_value("first_word", data, 18'h10040);
    wait_frames(1, 100);
    repeat (3) tick();
    check_value("directed_words", accepted, 19);
    check_value("directed_busy_cycles", busy_cnt, 20);
    check_value("directed_done_pulses", done_cnt, 1);
    check_value("directed_queue", exp_q.size(), 0);

    // Same frame with FIFO full toggling every clock
    full_mode = 1;
    clear_counts();
    push_frame(digits, leds, bright, on);
    pulse_update();
    wait_frames(1, 200);
    full_mode = 0;
    repeat (2) tick();
    check_value("toggle_words", accepted, 19);
    check_value("toggle_queue", exp_q.size(), 0);

    // Snapshot isolation and merged retriggers
    clear_counts();
    push_frame(digits, leds, bright, on);
    pulse_update();
    repeat (4) tick();
    digits = '1;
    tick();
    pulse_update();
    push_frame(digits, leds, bright, on);
    repeat (3) tick();
    pulse_update();
    wait_frames(2, 200);
    check_value("backtoback_busy_cycles", busy_cnt, 40);
    check_value("backtoback_queue", exp_q.size(), 0);
    repeat (30) tick();
    check_value("no_extra_frame", done_cnt, 2);

    // Display off, full brightness
    digits = {$urandom, $urandom}; on = 1'b0; bright = 3'd7;
    clear_counts();
    push_frame(digits, leds, bright, on);
    pulse_update();
    wait_frames(1, 100);
    check_value("ctrl_off_word", last_word, 18'h10087);
    check_value("ctrl_off_queue", exp_q.size(), 0);

    // Randomized frames with random backpressure and mid-frame input changes
    for (int f = 0; f < 8; f++) begin
      randomize_inputs();
      full_mode = 2;
      clear_counts();
      push_frame(digits, leds, bright, on);
      pulse_update();
      repeat ($urandom_range(1, 10)) tick();
      randomize_inputs();
      wait_frames(1, 400);
      check_value("rand_queue", exp_q.size(), 0);
    end
    full_mode = 0;
    repeat (2) tick();

    // Reset in the middle of a stalled frame
    digits = 64'h0706050403020100; leds = 8'hA5; bright = 3'd3; on = 1'b1;
    clear_counts();
    push_frame(digits, leds, bright, on);
    pulse_update();
    n = 0;
    while (accepted < 7 && n < 50) begin
      tick();
      n++;
    end
    check_value("reached_word7", accepted, 7);
    full_mode = 3;
    full = 1'b1;
    repeat (3) tick();
    check_value("stalled_valid", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_value("async_rst_valid", valid, 0);
    check_value("async_rst_busy", busy, 0);
    check_value("async_rst_data", data, 0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    full_mode = 0;
    full = 1'b0;
    tick();
    clear_counts();
    push_frame(digits, leds, bright, on);
    pulse_update();
    tick();
    check_value("restart_word", data, 18'h10040);
    wait_frames(1, 100);
    check_value("restart_queue", exp_q.size(), 0);

    // Periodic refresh and coincident request on the expiry cycle
    base = done_t_cnt;
    n = 0;
    while (done_t_cnt == base && n < 200) begin
      tick();
      n++;
    end
    check_value("timer_first_frame", done_t_cnt, base + 1);
    repeat (48) tick();
    upd_t = 1'b1;
    tick();
    upd_t = 1'b0;
    base = done_t_cnt;
    repeat (25) tick();
    check_value("coincident_busy", busy_t, 0);
    check_value("coincident_single", done_t_cnt - base, 1);
    repeat (150) tick();
    check_value("timer_frames", done_t_cnt - base, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm1638_frame_sequencer.md
Name: tm1638_frame_sequencer

Overview:
- Upstream producer for the TM1638 SPI FIFO stage.
- Snapshots display content (8 seven-segment digit bytes, 8 LEDs, brightness, on/off) and emits the complete TM1638 refresh transaction as a stream of 18-bit FIFO words.
- Respects the FIFO's full backpressure.
- Refresh is triggered by a request pulse or by an optional periodic timer.

Parameters:
- REFRESH_CYCLES, 0, auto-refresh period in clocks; 0 disables auto-refresh.
- WIDTH, 18, FIFO word width; fixed at 18, other values unsupported.

Ports:
- i_Clk  in  1  system clock; all logic on posedge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Update  in  1  single-cycle refresh request.
- i_Digits  in  64  segment bytes; digit n = i_Digits[8n+7:8n], n=0..7.
- i_Leds  in  8  LED n = i_Leds[n].
- i_Brightness  in  3  display pulse-width setting 0..7.
- i_Display_On  in  1  display enable.
- i_FIFO_Full  in  1  downstream FIFO full.
- o_Data_Valid  out  1  word offered to the FIFO.
- o_Data  out  18  word to the FIFO.
- o_Busy  out  1  transaction in progress.
- o_Frame_Done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Word format:
  - [17] = 0 (write).
  - [16] = END: STB is released after this byte.
  - [15:8] = 0.
  - [7:0] = byte, sent LSB-first by the downstream stage.
- Handshake:
  - A word is accepted on a clock edge where o_Data_Valid=1 and i_FIFO_Full=0.
  - While o_Data_Valid=1 and not accepted, o_Data is held stable.
  - o_Data_Valid never drops without acceptance, except on reset.
  - Throughput is 1 word/clock when not full.
- Reset values: o_Data_Valid=0, o_Data=0, o_Busy=0, o_Frame_Done=0, state IDLE, pending=0, refresh counter=0.
- Trigger:
  - i_Update=1, or the refresh counter reaching REFRESH_CYCLES-1 (when REFRESH_CYCLES>0).
  - In IDLE, a trigger snapshots all display inputs into internal registers and moves to DATA_CMD on the next edge; o_Busy=1 from that edge.
- States and sequence (19 words per frame):
  - DATA_CMD: 0x40, END=1 (auto-increment write).
  - ADDR_CMD: 0xC0, END=0.
  - PAYLOAD: 16 words, index k=0..15.
    - Even k: snapshot digit k/2.
    - Odd k: {7'b0, snapshot LED (k-1)/2}.
    - END=1 only at k=15.
  - CTRL_CMD: 0x80 | (on<<3) | brightness, END=1.
  - Then back to IDLE: o_Busy=0 and o_Frame_Done=1 for one cycle.
- Latency: first word is valid 1 clock after the trigger edge when the FIFO is not full.
- Snapshot: input changes during a frame do not affect the frame in progress.
- Trigger while busy:
  - Sets a single pending flag; further triggers while pending are merged.
  - On frame completion with pending=1, clear pending, take a new snapshot, and enter DATA_CMD directly; o_Busy stays 1 and o_Frame_Done still pulses.
- Refresh counter:
  - Free-runs only in IDLE with no pending request.
  - Clears on any trigger.
  - Wraps at REFRESH_CYCLES-1.
  - Coincident i_Update and counter expiry produce one frame.
- Full FIFO: the sequencer stalls indefinitely with the word held. A trigger arriving during the stall sets pending.
- Reset mid-frame: all outputs return to reset values immediately (async). No partial-frame resume; the downstream stage is reset by the same signal.

Test Plan:
- Reset, i_Digits=64'h0706050403020100, i_Leds=8'hA5, brightness=3, on=1, FIFO never full, pulse i_Update:
  - Expected stream: 0x10040, 0x000C0, 0x00, 0x01, 0x01, 0x00, 0x02, 0x01, ..., 0x07, then 0x10001 (digit 7 at k=14, LED7=1 at k=15), then 0x1008B.
  - o_Frame_Done pulses once; o_Busy is high for exactly 19 accept cycles plus 1.
- Same frame with i_FIFO_Full toggling 1-high/1-low every clock: identical 19-word sequence, no duplicates or drops, o_Data stable during every stalled cycle.
- Change i_Digits to all 8'hFF mid-frame: the current frame still carries the old values; then pulse i_Update mid-frame twice: exactly one more frame follows immediately, carrying 8'hFF digits.
- REFRESH_CYCLES=50, no i_Update: frames start every 50 idle cycles after the previous o_Frame_Done; i_Update on an expiry cycle yields a single frame.
- Assert i_Rst_n=0 at word 7 with i_FIFO_Full=1: o_Data_Valid, o_Busy, o_Data go to 0 asynchronously; after release, the next i_Update starts again from 0x10040.
- i_Display_On=0, brightness=7: final word is 0x10087.
